// File: rtl/mac_2s_to_signmag.sv
// Two's complement (WIDTH+1 bits) to {sign, WIDTH-bit magnitude} stream converter.
// Two register stages with valid/ready back-pressure, saturation of -2^WIDTH and a sticky event counter.
module mac_2s_to_signmag #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH:0]   i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [WIDTH-1:0] o_mant,
  output logic             o_sat,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_sat_cnt
);

  logic             s1_v_q, s1_v_d;
  logic             s1_sign_q, s1_sign_d;
  logic [WIDTH-1:0] s1_bits_q, s1_bits_d;
  logic             s1_min_q, s1_min_d;

  logic             s2_v_q, s2_v_d;
  logic             s2_sign_q, s2_sign_d;
  logic [WIDTH-1:0] s2_mant_q, s2_mant_d;
  logic             s2_sat_q, s2_sat_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, s2_adv, sat_inc;
  logic [WIDTH:0]   sum;

  always_comb begin
    s2_adv    = !s2_v_q || i_ready;
    s1_adv    = !s1_v_q || s2_adv;

    s1_v_d    = s1_v_q;
    s1_sign_d = s1_sign_q;
    s1_bits_d = s1_bits_q;
    s1_min_d  = s1_min_q;
    s2_v_d    = s2_v_q;
    s2_sign_d = s2_sign_q;
    s2_mant_d = s2_mant_q;
    s2_sat_d  = s2_sat_q;
    cnt_d     = cnt_q;

    if (s1_adv) begin
      s1_v_d = i_valid;
      if (i_valid) begin
        s1_sign_d = i_data[WIDTH];
        s1_bits_d = i_data[WIDTH] ? ~i_data[WIDTH-1:0] : i_data[WIDTH-1:0];
        s1_min_d  = (i_data == {1'b1, {WIDTH{1'b0}}});
      end
    end

    sum = {1'b0, s1_bits_q} + {{WIDTH{1'b0}}, s1_sign_q};

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        // A carry out of the increment only happens for -2^WIDTH, same as s1_min.
        if (s1_min_q || sum[WIDTH]) begin
          s2_sign_d = 1'b1;
          s2_mant_d = '1;
          s2_sat_d  = 1'b1;
        end else begin
          s2_sign_d = s1_sign_q && (|sum[WIDTH-1:0]);
          s2_mant_d = sum[WIDTH-1:0];
          s2_sat_d  = 1'b0;
        end
      end
    end

    sat_inc = s2_v_q && i_ready && s2_sat_q;
    if (i_clr_cnt) begin
      cnt_d = sat_inc ? CNT_W'(1) : '0;
    end else if (sat_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_bits_q <= '0;
      s1_min_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_mant_q <= '0;
      s2_sat_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_sign_q <= s1_sign_d;
      s1_bits_q <= s1_bits_d;
      s1_min_q  <= s1_min_d;
      s2_v_q    <= s2_v_d;
      s2_sign_q <= s2_sign_d;
      s2_mant_q <= s2_mant_d;
      s2_sat_q  <= s2_sat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_ready   = s1_adv;
  assign o_valid   = s2_v_q;
  assign o_sign    = s2_sign_q;
  assign o_mant    = s2_mant_q;
  assign o_sat     = s2_sat_q;
  assign o_sat_cnt = cnt_q;

endmodule
